// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel stream controller.
// Holds the controller FSM state type, the default frame geometry and a
// helper that sizes the column/row counters.
package sobel_pkg;

  localparam int unsigned ImgWDefault = 640;
  localparam int unsigned ImgHDefault = 480;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitSop = 2'd1,
    StActive  = 2'd2,
    StDrop    = 2'd3
  } state_e;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/sobel_ctrl_if.sv
// Stream bundle around the Sobel controller.
//   pix_*      : upstream binary pixel stream (into the controller)
//   sob_din/.. : stream driven into the Sobel datapath
//   sob_dout*  : Sobel datapath result stream (into the controller)
//   dout*      : cleaned edge stream to the display path
// Modports: slave = controller side, master = environment side.
interface sobel_ctrl_if;

  logic pix_in;
  logic pix_sop;
  logic pix_eop;
  logic pix_vld;

  logic sob_din;
  logic sob_sop;
  logic sob_eop;
  logic sob_vld;

  logic sob_dout;
  logic sob_dout_sop;
  logic sob_dout_eop;
  logic sob_dout_vld;

  logic dout;
  logic dout_sop;
  logic dout_eop;
  logic dout_vld;

  modport slave (
    input  pix_in, pix_sop, pix_eop, pix_vld,
    input  sob_dout, sob_dout_sop, sob_dout_eop, sob_dout_vld,
    output sob_din, sob_sop, sob_eop, sob_vld,
    output dout, dout_sop, dout_eop, dout_vld
  );

  modport master (
    output pix_in, pix_sop, pix_eop, pix_vld,
    output sob_dout, sob_dout_sop, sob_dout_eop, sob_dout_vld,
    input  sob_din, sob_sop, sob_eop, sob_vld,
    input  dout, dout_sop, dout_eop, dout_vld
  );

endinterface

// File: rtl/sobel_pos_cnt.sv
// Column/row position counter for a raster of IMG_W x IMG_H beats.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the raster at (0,0)
//   inc        : advance one beat; with clr, advances from (0,0)
//   col, row   : position of the current beat
//   last       : current position is the final beat of the frame
module sobel_pos_cnt
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         inc,
  output logic [cnt_width(IMG_W)-1:0]  col,
  output logic [cnt_width(IMG_H)-1:0]  row,
  output logic                         last
);

  localparam int unsigned ColW = cnt_width(IMG_W);
  localparam int unsigned RowW = cnt_width(IMG_H);
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);

  logic [ColW-1:0] col_q, col_d, col_base;
  logic [RowW-1:0] row_q, row_d, row_base;

  always_comb begin
    col_base = clr ? '0 : col_q;
    row_base = clr ? '0 : row_q;
    col_d    = col_base;
    row_d    = row_base;
    if (inc) begin
      if (col_base == ColMax) begin
        col_d = '0;
        row_d = (row_base == RowMax) ? '0 : row_base + 1'b1;
      end else begin
        col_d = col_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == ColMax) && (row_q == RowMax);

endmodule

// File: rtl/sobel_ctrl.sv
// Frame controller wrapped around a binary Sobel datapath.
// Accepts framed pixel beats while enabled, checks frame geometry, forwards
// good beats to the datapath with one registered cycle, and registers the
// datapath result towards the display path.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : level enable; new frames start only while high
//   bus        : stream bundle (sobel_ctrl_if.slave)
//   busy       : high while a frame is being accepted
//   frame_err  : one-cycle pulse when a malformed frame is detected
// Build option: define SOBEL_BORDER_MASK_EN to zero result beats whose 3x3
// window is incomplete (row < 2 or col < 2).
module sobel_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  sobel_ctrl_if.slave       bus,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned ColW = cnt_width(IMG_W);
  localparam int unsigned RowW = cnt_width(IMG_H);

  state_e state_q, state_d;

  logic            fwd, fwd_sop, fwd_eop, err;
  logic            in_clr, in_inc, in_last;
  logic [ColW-1:0] in_col;
  logic [RowW-1:0] in_row;

  logic sob_din_q, sob_sop_q, sob_eop_q, sob_vld_q, frame_err_q;
  logic dout_q, dout_sop_q, dout_eop_q, dout_vld_q;
  logic armed_q;
  logic dout_d;

  // Input-side position; held at (0,0) outside a frame so the sop beat
  // always lands on position 0.
  sobel_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_in_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_clr),
    .inc   (in_inc),
    .col   (in_col),
    .row   (in_row),
    .last  (in_last)
  );

  always_comb begin
    state_d = state_q;
    fwd     = 1'b0;
    fwd_sop = 1'b0;
    fwd_eop = 1'b0;
    err     = 1'b0;
    in_clr  = 1'b0;
    in_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_clr = 1'b1;
        if (en) state_d = StWaitSop;
      end
      StWaitSop, StDrop: begin
        in_clr = 1'b1;
        if (state_q == StWaitSop && !en) begin
          state_d = StIdle;
        end else if (bus.pix_vld && bus.pix_sop) begin
          if (!en) begin
            state_d = StIdle;
          end else if (bus.pix_eop && !in_last) begin
            // Frame starts and ends on the same beat: too short.
            err     = 1'b1;
            state_d = StDrop;
          end else begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            in_inc  = 1'b1;
            if (in_last) begin
              fwd_eop = 1'b1;
              state_d = StWaitSop;
            end else begin
              state_d = StActive;
            end
          end
        end
      end
      StActive: begin
        if (bus.pix_vld) begin
          if (bus.pix_sop || (bus.pix_eop && !in_last)) begin
            err     = 1'b1;
            in_clr  = 1'b1;
            state_d = StDrop;
          end else begin
            fwd    = 1'b1;
            in_inc = 1'b1;
            if (in_last) begin
              // Geometry, not pix_eop, defines the end of frame.
              fwd_eop = 1'b1;
              state_d = en ? StWaitSop : StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sob_din_q   <= 1'b0;
      sob_sop_q   <= 1'b0;
      sob_eop_q   <= 1'b0;
      sob_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sob_din_q   <= fwd & bus.pix_in;
      sob_sop_q   <= fwd_sop;
      sob_eop_q   <= fwd_eop;
      sob_vld_q   <= fwd;
      frame_err_q <= err;
    end
  end

`ifdef SOBEL_BORDER_MASK_EN
  logic [ColW-1:0] out_col, eff_col;
  logic [RowW-1:0] out_row, eff_row;
  logic            out_last;
  logic            border;

  sobel_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_out_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.sob_dout_sop),
    .inc   (bus.sob_dout_vld),
    .col   (out_col),
    .row   (out_row),
    .last  (out_last)
  );

  // The sop beat itself is position (0,0) whatever the counter holds.
  always_comb begin
    eff_col = bus.sob_dout_sop ? '0 : out_col;
    eff_row = bus.sob_dout_sop ? '0 : out_row;
    border  = (32'(eff_row) < 32'd2) || (32'(eff_col) < 32'd2);
    dout_d  = bus.sob_dout & ~border;
  end
`else
  assign dout_d = bus.sob_dout;
`endif

  // armed_q keeps the result path quiet for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      dout_q     <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      dout_q     <= armed_q & dout_d;
      dout_sop_q <= armed_q & bus.sob_dout_sop;
      dout_eop_q <= armed_q & bus.sob_dout_eop;
      dout_vld_q <= armed_q & bus.sob_dout_vld;
    end
  end

  assign bus.sob_din  = sob_din_q;
  assign bus.sob_sop  = sob_sop_q;
  assign bus.sob_eop  = sob_eop_q;
  assign bus.sob_vld  = sob_vld_q;
  assign bus.dout     = dout_q;
  assign bus.dout_sop = dout_sop_q;
  assign bus.dout_eop = dout_eop_q;
  assign bus.dout_vld = dout_vld_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q == StActive);

endmodule

// File: tb/tb_sobel_ctrl.sv
// Self-checking bench for sobel_ctrl with an 8x4 frame.
module tb_sobel_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int N = W * H;
`ifdef SOBEL_BORDER_MASK_EN
  localparam bit Mask = 1'b1;
`else
  localparam bit Mask = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic busy;
  logic frame_err;

  sobel_ctrl_if bus ();

  sobel_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic s;
    logic e;
  } beat_t;

  typedef struct {
    logic s;
    logic e;
    logic en;
    bit   xfwd;
    bit   xsop;
    bit   xeop;
    bit   xerr;
  } vec_t;

  beat_t sq_exp[$];
  beat_t dq_exp[$];
  vec_t  tbl[$];

  int checks = 0;
  int failures = 0;
  int sob_seen = 0;
  int eop_seen = 0;
  int err_seen = 0;
  int ones_seen = 0;
  int oc = 0;
  int orow = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : mon
    beat_t g;
    beat_t x;
    if (bus.sob_vld === 1'b1) begin
      sob_seen++;
      if (bus.sob_eop) eop_seen++;
      g = {bus.sob_din, bus.sob_sop, bus.sob_eop};
      if (sq_exp.size() == 0) begin
        chk("sob_unexpected", 32'(bus.sob_vld), 32'd0);
      end else begin
        x = sq_exp.pop_front();
        chk("sob_beat", 32'(g), 32'(x));
      end
    end
    if (bus.dout_vld === 1'b1) begin
      if (bus.dout) ones_seen++;
      g = {bus.dout, bus.dout_sop, bus.dout_eop};
      if (dq_exp.size() == 0) begin
        chk("dout_unexpected", 32'(bus.dout_vld), 32'd0);
      end else begin
        x = dq_exp.pop_front();
        chk("dout_beat", 32'(g), 32'(x));
      end
    end
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic clear_inputs();
    bus.pix_in = 1'b0; bus.pix_sop = 1'b0; bus.pix_eop = 1'b0; bus.pix_vld = 1'b0;
    bus.sob_dout = 1'b0; bus.sob_dout_sop = 1'b0; bus.sob_dout_eop = 1'b0;
    bus.sob_dout_vld = 1'b0;
  endtask

  task automatic check_outs_zero(input string name);
    chk(name, 32'({bus.sob_din, bus.sob_sop, bus.sob_eop, bus.sob_vld, bus.dout, bus.dout_sop,
                   bus.dout_eop, bus.dout_vld, busy, frame_err}), 32'd0);
  endtask

  // Release reset with live-looking inputs; nothing may appear on the
  // first cycle afterwards.
  task automatic do_release();
    bus.pix_vld = 1'b1; bus.pix_sop = 1'b1;
    bus.sob_dout_vld = 1'b1; bus.sob_dout_sop = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs_zero("first_cycle_after_reset");
    clear_inputs();
  endtask

  task automatic pix_beat(input logic s, input logic e, input bit xfwd, input bit xsop,
                          input bit xeop);
    logic d;
    d = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.pix_in = d; bus.pix_sop = s; bus.pix_eop = e; bus.pix_vld = 1'b1;
    if (xfwd) sq_exp.push_back({d, logic'(xsop), logic'(xeop)});
  endtask

  task automatic pix_idle();
    @(posedge clk);
    #1;
    bus.pix_vld = 1'b0; bus.pix_sop = 1'b0; bus.pix_eop = 1'b0;
  endtask

  // Full well-formed frame; en drops before beat en_off_at (if >= 0).
  task automatic frame_clean(input int en_off_at);
    int s0, e0, r0;
    s0 = sob_seen; e0 = eop_seen; r0 = err_seen;
    for (int i = 0; i < N; i++) begin
      if (i == en_off_at) en = 1'b0;
      pix_beat(i == 0, i == N - 1, 1'b1, i == 0, i == N - 1);
      @(negedge clk);
      chk("busy_in_frame", 32'(busy), 32'(i > 0));
    end
    pix_idle();
    @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    @(negedge clk);
    chk("frame_sob_count", 32'(sob_seen - s0), 32'(N));
    chk("frame_eop_count", 32'(eop_seen - e0), 32'd1);
    chk("frame_err_count", 32'(err_seen - r0), 32'd0);
  endtask

  task automatic add_vec(input logic s, input logic e, input bit xfwd, input bit xsop,
                         input bit xeop, input bit xerr);
    tbl.push_back('{s, e, 1'b1, xfwd, xsop, xeop, xerr});
  endtask

  // Result-path beat; expected dout from a position model of the raster.
  task automatic sd_beat(input logic d, input logic s, input logic e);
    logic x;
    @(posedge clk);
    #1;
    bus.sob_dout = d; bus.sob_dout_sop = s; bus.sob_dout_eop = e; bus.sob_dout_vld = 1'b1;
    if (s) begin
      oc = 0;
      orow = 0;
    end
    x = Mask ? (d & (orow >= 2) & (oc >= 2)) : d;
    dq_exp.push_back({x, s, e});
    if (oc == int'(W) - 1) begin
      oc = 0;
      orow = (orow == int'(H) - 1) ? 0 : orow + 1;
    end else begin
      oc++;
    end
  endtask

  task automatic sd_idle();
    @(posedge clk);
    #1;
    bus.sob_dout_vld = 1'b0; bus.sob_dout_sop = 1'b0; bus.sob_dout_eop = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int r0, s0, o0;
    rst_n = 1'b0;
    en = 1'b1;
    clear_inputs();

    // Stimulus table: WAIT_SOP junk, early eop, DROP, sop+eop, stray sop,
    // then a frame whose last beat lacks pix_eop.
    add_vec(0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 1, 1, 0, 0);
    for (int k = 1; k < 10; k++) add_vec(0, 0, 1, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0);
    add_vec(1, 1, 0, 0, 0, 1);
    add_vec(1, 0, 1, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 1);
    add_vec(1, 0, 1, 1, 0, 0);
    for (int k = 1; k < N - 1; k++) add_vec(0, 0, 1, 0, 0, 0);
    add_vec(0, 0, 1, 0, 1, 0);

    // Reset with inputs active.
    bus.pix_vld = 1'b1; bus.pix_sop = 1'b1;
    bus.sob_dout_vld = 1'b1; bus.sob_dout_sop = 1'b1;
    repeat (3) @(negedge clk);
    check_outs_zero("reset_outs");
    do_release();

    // Clean frame.
    frame_clean(-1);

    // Table-driven sequence.
    r0 = err_seen;
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en;
      pix_beat(tbl[i].s, tbl[i].e, tbl[i].xfwd, tbl[i].xsop, tbl[i].xeop);
      @(negedge clk);
      if (i > 0) chk("tbl_frame_err", 32'(frame_err), 32'(tbl[i-1].xerr));
    end
    pix_idle();
    @(negedge clk);
    chk("tbl_frame_err", 32'(frame_err), 32'(tbl[tbl.size()-1].xerr));
    @(negedge clk);
    chk("tbl_err_count", 32'(err_seen - r0), 32'd3);

    // en falls mid-frame: frame completes, then the next sop is ignored.
    frame_clean(5);
    s0 = sob_seen;
    pix_beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pix_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pix_idle();
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sop_ignored", 32'(sob_seen - s0), 32'd0);
    en = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame.
    for (int i = 0; i < 15; i++) begin
      pix_beat(i == 0, 1'b0, 1'b1, i == 0, 1'b0);
      @(negedge clk);
    end
    pix_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs_zero("reset_async_outs");
    clear_inputs();
    do_release();
    s0 = sob_seen;
    for (int i = 0; i < 3; i++) pix_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pix_idle();
    repeat (2) @(negedge clk);
    chk("post_reset_no_sop_dropped", 32'(sob_seen - s0), 32'd0);
    frame_clean(-1);

    // Result path: constant 1, then a short frame restarted by a new sop.
    o0 = ones_seen;
    for (int i = 0; i < N; i++) sd_beat(1'b1, i == 0, i == N - 1);
    sd_idle();
    repeat (2) @(negedge clk);
    chk("dout_ones", 32'(ones_seen - o0), Mask ? 32'd12 : 32'(N));
    for (int i = 0; i < 5; i++) sd_beat(1'($urandom_range(0, 1)), i == 0, 1'b0);
    for (int i = 0; i < 20; i++) sd_beat(1'($urandom_range(0, 1)), i == 0, i == 19);
    sd_idle();

    for (int k = 0; k < 10 && (sq_exp.size() != 0 || dq_exp.size() != 0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("sob_queue_empty", 32'(sq_exp.size()), 32'd0);
    chk("dout_queue_empty", 32'(dq_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
